// File: rtl/simd_inst_encoder.sv
// SIMD instruction encoder: packs field requests into 16-bit words and queues them in a FIFO.
// Illegal requests become the canonical NOP, and each one is counted in a saturating counter.
module simd_inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 opcode,
  input  logic [2:0]                 data_mode,
  input  logic                       imm_flag,
  input  logic [7:0]                 imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                inst,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [15:0] NOP_WORD = 16'h0100;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          legal;
  logic [15:0]   enc_word;
  logic          push;
  logic          pop;

  assign legal    = (opcode <= 4'b1001) && (data_mode <= 3'b101);
  assign enc_word = legal ? {opcode, data_mode, imm_flag, imm} : NOP_WORD;

  // Full blocks pushes outright, so a pop in the same cycle cannot make room.
  assign in_ready  = (count != FULL_CNT) && !flush;
  assign out_valid = (count != '0);
  assign inst      = out_valid ? mem[rd_ptr] : 16'h0000;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Storage has no reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flush leaves the error history intact; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (push && !legal && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_simd_inst_encoder.sv
// Self-checking bench for simd_inst_encoder: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_simd_inst_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [2:0]    data_mode;
  logic          imm_flag;
  logic [7:0]    imm;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   inst;
  logic [AW:0]   count;
  logic [7:0]    err_cnt;

  int nchecks = 0;
  int nerr    = 0;

  logic [15:0] model_q[$];
  int          model_err = 0;

  simd_inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .data_mode (data_mode),
    .imm_flag  (imm_flag),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst      (inst),
    .count     (count),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int sz;
    sz = model_q.size();
    check({tag, ".in_ready"}, {15'd0, in_ready}, {15'd0, (!flush && sz < DEPTH)});
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, (sz > 0)});
    check({tag, ".inst"}, inst, (sz > 0) ? model_q[0] : 16'h0000);
    check({tag, ".count"}, 16'(count), 16'(sz));
    check({tag, ".err_cnt"}, {8'd0, err_cnt}, 16'(model_err));
  endtask

  // Drive one cycle of inputs, check the pre-edge outputs, then advance the model.
  task automatic applyStimulus(input string tag, input logic r, input logic f, input logic iv,
                               input logic [3:0] op, input logic [2:0] dm, input logic ifl,
                               input logic [7:0] im, input logic ordy);
    int  sz;
    bit  do_push;
    bit  do_pop;
    bit  ok;
    rst = r; flush = f; in_valid = iv; opcode = op; data_mode = dm;
    imm_flag = ifl; imm = im; out_ready = ordy;
    #1;
    checkOutput(tag);
    sz      = model_q.size();
    do_push = iv && !f && (sz < DEPTH);
    do_pop  = ordy && (sz > 0);
    ok      = (int'(op) <= 9) && (int'(dm) <= 5);
    @(posedge clk);
    if (r) begin
      model_q.delete();
      model_err = 0;
    end else if (f) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back(ok ? {op, dm, ifl, im} : 16'h0100);
        if (!ok && model_err < 255) model_err++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; opcode = '0; data_mode = '0;
    imm_flag = 1'b0; imm = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus("reset_state", 0, 0, 0, 4'd0, 3'd0, 0, 8'h00, 0);

    // Legal pack into an empty FIFO, then drain.
    applyStimulus("legal_push", 0, 0, 1, 4'd1, 3'd2, 0, 8'h5A, 0);
    applyStimulus("legal_head", 0, 0, 0, 4'd0, 3'd0, 0, 8'h00, 1);
    applyStimulus("legal_drained", 0, 0, 0, 4'd0, 3'd0, 0, 8'h00, 0);

    // Illegal conversion: bad opcode, then bad data_mode.
    applyStimulus("illegal_op", 0, 0, 1, 4'hC, 3'd3, 0, 8'hFF, 0);
    applyStimulus("illegal_dm", 0, 0, 1, 4'd2, 3'd6, 1, 8'h33, 0);
    applyStimulus("illegal_pop1", 0, 0, 0, 4'd0, 3'd0, 0, 8'h00, 1);
    applyStimulus("illegal_pop2", 0, 0, 0, 4'd0, 3'd0, 0, 8'h00, 1);

    // Full and backpressure: five pushes with the sink stalled.
    for (int i = 0; i < 5; i++)
      applyStimulus("full_push", 0, 0, 1, 4'(i + 1), 3'd1, 0, 8'(8'h10 + i), 0);
    applyStimulus("full_pop", 0, 0, 1, 4'd5, 3'd1, 0, 8'h14, 1);
    applyStimulus("full_after", 0, 0, 1, 4'd5, 3'd1, 0, 8'h14, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus("full_drain", 0, 0, 0, 4'd0, 3'd0, 0, 8'h00, 1);

    // Streaming ten words with both sides always ready.
    for (int i = 0; i < 10; i++)
      applyStimulus("stream", 0, 0, 1, 4'(i % 10), 3'(i % 6), 1'(i), 8'(8'hA0 + i), 1);
    applyStimulus("stream_tail", 0, 0, 0, 4'd0, 3'd0, 0, 8'h00, 1);

    // Flush with three words queued and an input offered, then reset.
    for (int i = 0; i < 3; i++)
      applyStimulus("flush_fill", 0, 0, 1, 4'd3, 3'd4, 0, 8'(i), 0);
    applyStimulus("flush", 0, 1, 1, 4'd7, 3'd1, 0, 8'h77, 1);
    applyStimulus("flush_after", 0, 0, 0, 4'd0, 3'd0, 0, 8'h00, 0);
    applyStimulus("reset_mid", 1, 0, 1, 4'd1, 3'd1, 0, 8'h01, 1);
    applyStimulus("reset_after", 0, 0, 0, 4'd0, 3'd0, 0, 8'h00, 0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++)
      applyStimulus("saturate", 0, 0, 1, 4'hF, 3'd7, 0, 8'h00, 1);
    applyStimulus("saturate_end", 0, 0, 0, 4'd0, 3'd0, 0, 8'h00, 1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 250; i++)
      applyStimulus("random", ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                    1'($urandom), 4'($urandom_range(0, 11)), 3'($urandom), 1'($urandom),
                    8'($urandom), 1'($urandom));
    applyStimulus("final", 0, 0, 0, 4'd0, 3'd0, 0, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/simd_inst_encoder.md
SIMD_INST_ENCODER -- requirements
Module: simd_inst_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction FIFO depth in entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port flush  input  1  synchronous clear of the FIFO contents.
REQ-005 SHALL have port in_valid  input  1  field request present.
REQ-006 SHALL have port in_ready  output  1  field request is accepted this cycle.
REQ-007 SHALL have port opcode  input  4  operation code (0 NOP, 1 PADD ... 9 PUNPKGHI).
REQ-008 SHALL have port data_mode  input  3  element width mode.
REQ-009 SHALL have port imm_flag  input  1  immediate-operand select.
REQ-010 SHALL have port imm  input  8  immediate value.
REQ-011 SHALL have port out_valid  output  1  inst holds a valid word.
REQ-012 SHALL have port out_ready  input  1  downstream decoder accepts inst.
REQ-013 SHALL have port inst  output  16  packed instruction word.
REQ-014 SHALL have port count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have port err_cnt  output  8  number of illegal requests converted to NOP.

Function
REQ-016 SHALL pack legal requests as inst = {opcode, data_mode, imm_flag, imm}.
REQ-017 SHALL treat a request as legal only if opcode <= 4'b1001 and data_mode <= 3'b101.
REQ-018 SHALL encode an illegal request as the canonical NOP 16'h0100 (opcode 0, data_mode 0, imm_flag 1, imm 0) and push it into the FIFO.
REQ-019 SHALL increment err_cnt on each accepted illegal request, saturating at 8'hFF.
REQ-020 SHALL accept a request (push) when in_valid and in_ready are both high on a rising clk edge.
REQ-021 SHALL drive in_ready = (count != DEPTH) and not flush; no push-through when full, even with a simultaneous pop.
REQ-022 SHALL perform a pop when out_valid and out_ready are both high on a rising clk edge.
REQ-023 SHALL drive out_valid = (count != 0) and inst = head entry; inst SHALL be 16'h0000 when count = 0.
REQ-024 SHALL present a word pushed at edge N on inst/out_valid after edge N when the FIFO was empty (1-cycle latency); with no push-through bypass.
REQ-025 SHALL, on a simultaneous push and pop with 0 < count < DEPTH, leave count unchanged and preserve FIFO order.
REQ-026 SHALL keep inst and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL wrap read and write pointers modulo DEPTH without loss or duplication of entries.
REQ-028 SHALL, on flush, set count to 0 and the pointers to 0, and discard any simultaneous push and pop; err_cnt is unaffected.
REQ-029 SHALL ignore out_ready when count = 0 and ignore in_valid when in_ready = 0, with no state change.

Reset
REQ-030 SHALL, on rst high at a rising edge, set count = 0, pointers = 0, and err_cnt = 0; out_valid = 0, inst = 16'h0000, and in_ready = 1 after that edge.
REQ-031 SHALL give rst priority over flush, push, and pop; rst mid-transfer discards all FIFO contents.
REQ-032 SHALL not require storage contents to be cleared by rst; only occupancy and pointers are cleared.

Verification
REQ-033 SHALL cover legal pack: push opcode 1, data_mode 2, imm_flag 0, imm 8'h5A into an empty FIFO -> next cycle out_valid = 1, inst = 16'h145A, count = 1.
REQ-034 SHALL cover illegal conversion: push opcode 4'hC, data_mode 3, imm 8'hFF -> inst = 16'h0100, err_cnt = 1; then push data_mode 6 -> inst 16'h0100, err_cnt = 2.
REQ-035 SHALL cover full/backpressure: DEPTH = 4, out_ready = 0, push 5 words -> in_ready = 0 after the 4th push, count = 4, the 5th is not accepted; pop one with in_valid high -> 5th accepted next cycle; order preserved.
REQ-036 SHALL cover streaming: in_valid = 1 and out_ready = 1 continuously for 10 words -> count stays at 1 after the first, all 10 words appear in order, and the pointers wrap twice.
REQ-037 SHALL cover flush/reset: with 3 words queued and err_cnt = 2, assert flush with in_valid = 1 -> count = 0, out_valid = 0, the input is dropped, err_cnt = 2; then assert rst -> err_cnt = 0.
REQ-038 SHALL cover saturation: 300 illegal pushes with out_ready = 1 -> err_cnt = 8'hFF.
